// File: rtl/key_input.sv
// Debounced push-button and synchronized switch input block.
// Keys produce sticky press-event flags with a shared interrupt line.
module key_input #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       clock,
  input  logic       reset_s2_n,
  input  logic       enable,
  input  logic [3:0] key_n,
  input  logic [7:0] sw,
  input  logic [3:0] clear,
  output logic [3:0] key_state,
  output logic [3:0] pending,
  output logic       irq,
  output logic [7:0] sw_data
);

  localparam int unsigned NKEY  = 4;
  localparam int unsigned NSW   = 8;
  localparam int unsigned CNT_W = 20;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NKEY-1:0]            key_meta_q, key_sync_q;
  logic [NSW-1:0]             sw_meta_q, sw_sync_q;
  logic [NKEY-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NKEY-1:0]            key_state_q, key_state_d;
  logic [NKEY-1:0]            pending_q, pending_d;
  logic [NKEY-1:0]            raw_p;

  // Two-flop synchronizers; key lines idle high so they reset to 1.
  always_ff @(posedge clock or negedge reset_s2_n) begin
    if (!reset_s2_n) begin
      key_meta_q <= '1;
      key_sync_q <= '1;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
    end else begin
      key_meta_q <= key_n;
      key_sync_q <= key_meta_q;
      sw_meta_q  <= sw;
      sw_sync_q  <= sw_meta_q;
    end
  end

  // Per-key debounce counter, level toggle and press-event capture.
  always_comb begin
    raw_p       = ~key_sync_q;
    cnt_d       = '0;
    key_state_d = key_state_q;
    pending_d   = pending_q & ~clear;
    for (int unsigned i = 0; i < NKEY; i++) begin
      if (raw_p[i] != key_state_q[i]) begin
        if (cnt_q[i] >= CNT_MAX) begin
          key_state_d[i] = ~key_state_q[i];
          // A press on the same edge as a clear keeps the flag set.
          if (!key_state_q[i] && enable) begin
            pending_d[i] = 1'b1;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_s2_n) begin
    if (!reset_s2_n) begin
      cnt_q       <= '0;
      key_state_q <= '0;
      pending_q   <= '0;
    end else begin
      cnt_q       <= cnt_d;
      key_state_q <= key_state_d;
      pending_q   <= pending_d;
    end
  end

  assign key_state = key_state_q;
  assign pending   = pending_q;
  assign irq       = |pending_q;
  assign sw_data   = sw_sync_q;

endmodule

// File: doc/key_input.md
KEY_INPUT -- requirements
Module: key_input

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, meaning consecutive stable cycles required to accept a key change (10 ms at 50 MHz); legal range 2..2^20-1.
REQ-002 clock  input  1  50 MHz system clock; all state changes on its rising edge.
REQ-003 reset_s2_n  input  1  synchronized inverted reset; asynchronous, active-low.
REQ-004 enable  input  1  when high, press events are recorded.
REQ-005 key_n  input  4  raw push-buttons, active-low, asynchronous to clock.
REQ-006 sw  input  8  raw slide switches, asynchronous to clock.
REQ-007 clear  input  4  per-key pending clear mask from CPU, one-cycle pulse per bit.
REQ-008 key_state  output  4  debounced key level, 1 = pressed.
REQ-009 pending  output  4  sticky press-event flags.
REQ-010 irq  output  1  OR of pending.
REQ-011 sw_data  output  8  synchronized switch value.

Function
REQ-012 Each key_n and sw bit SHALL pass through a two-flop synchronizer before any other use.
REQ-013 Per key: raw_p[i] = inverted synchronized key_n[i]; a 20-bit counter cnt[i] SHALL exist per key.
REQ-014 When raw_p[i] == key_state[i], cnt[i] SHALL be 0 on the next edge.
REQ-015 When raw_p[i] != key_state[i] and cnt[i] < DEBOUNCE_CYCLES-1, cnt[i] SHALL increment by 1.
REQ-016 When raw_p[i] != key_state[i] and cnt[i] == DEBOUNCE_CYCLES-1, key_state[i] SHALL toggle and cnt[i] SHALL be 0 on that edge.
REQ-017 Net: key_state[i] changes on the DEBOUNCE_CYCLES-th consecutive edge with raw_p[i] differing; any single-cycle return to equality restarts the count.
REQ-018 End-to-end latency from a stable key_n change to key_state change SHALL be DEBOUNCE_CYCLES+2 cycles.
REQ-019 Press event: pending[i] SHALL be set on the same edge key_state[i] transitions 0->1, only if enable is high on that edge.
REQ-020 Release (1->0) transitions SHALL NOT affect pending.
REQ-021 clear[i] high SHALL clear pending[i] on the next edge.
REQ-022 Simultaneous press event and clear[i] on one bit: set wins, pending[i] = 1.
REQ-023 Keys are independent; simultaneous events on several keys SHALL each set their own bit.
REQ-024 enable low SHALL NOT stall debouncing or alter existing pending bits; clear SHALL still act.
REQ-025 irq SHALL equal |pending combinationally from registered bits (glitch-free, same cycle as pending).
REQ-026 sw_data SHALL equal the second synchronizer stage of sw, latency 2 cycles, independent of enable.
REQ-027 Counters SHALL never exceed DEBOUNCE_CYCLES-1; no wrap-around.

Reset
REQ-028 On reset_s2_n low, asynchronously: key_n synchronizers = 1, sw synchronizers = 0, all cnt = 0, key_state = 0, pending = 0, irq = 0, sw_data = 0.
REQ-029 Reset mid-debounce SHALL discard the count; after release a held key SHALL require a full DEBOUNCE_CYCLES+2 cycles to register.
REQ-030 First rising edge after reset release SHALL follow REQ-012..REQ-027 with no extra delay.

Verification (DEBOUNCE_CYCLES=4)
REQ-031 key_n=4'b1110 held, enable=1 -> key_state=4'b0001, pending=4'b0001, irq=1 exactly 6 cycles after the key_n change.
REQ-032 key_n[0] low 3 cycles, high 1, low 3 -> key_state and pending remain 0.
REQ-033 pending=4'b0001, clear=4'b0001 for one cycle -> pending=0, irq=0 next cycle; clear pulse on the same edge as a key1 press event -> pending=4'b0010.
REQ-034 enable=0 during key2 press -> key_state[2]=1, pending=0; key2 released and re-pressed with enable=1 -> pending=4'b0100.
REQ-035 sw=8'hA5 -> sw_data=8'hA5 after 2 cycles; reset asserted while key3 count=2 -> all outputs 0 immediately; key still held -> key_state[3]=1 6 cycles after release.
